// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C requester arbiter.
//   arb_state_t : sequencer states (IDLE, ISSUE, WAIT, DONE)
//   I2C_ADDR_W  : 7-bit I2C target address width
//   I2C_DATA_W  : single data byte width
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/i2c_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req     : per-requester request bits
//   ptr     : index of the previous winner; search starts at ptr+1
//   en      : enables the pick; gnt is all-zero when low
//   gnt     : one-hot winner
//   gnt_idx : binary index of the winner
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        if (en) begin
            // Walk ptr+1 .. ptr+N with wrap, first set bit wins.
            for (int unsigned k = 1; k <= N; k++) begin
                idx = 32'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (!found && req[idx[IW-1:0]]) begin
                    found                = 1'b1;
                    gnt[idx[IW-1:0]]     = 1'b1;
                    gnt_idx              = idx[IW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one i2c_master between N_REQ requesters, one single-byte
// transaction at a time, with round-robin fairness.
//   req/req_addr/req_rw/req_wdata : requester side transaction posts
//   ack                           : one-cycle completion pulse to the winner
//   rdata/err_nack/err_tmo        : result, valid in the ack cycle
//   m_addr/m_rw/m_data_w/m_start  : command to the master
//   m_data_out/m_valid_out/m_busy/m_erro_addr : status from the master
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_REQ-1:0]                     req,
    input  logic [N_REQ-1:0][I2C_ADDR_W-1:0]     req_addr,
    input  logic [N_REQ-1:0]                     req_rw,
    input  logic [N_REQ-1:0][I2C_DATA_W-1:0]     req_wdata,
    output logic [N_REQ-1:0]                     ack,
    output logic [I2C_DATA_W-1:0]                rdata,
    output logic                                 err_nack,
    output logic                                 err_tmo,
    output logic [I2C_ADDR_W-1:0]                m_addr,
    output logic                                 m_rw,
    output logic [I2C_DATA_W-1:0]                m_data_w,
    output logic                                 m_start,
    input  logic [I2C_DATA_W-1:0]                m_data_out,
    input  logic                                 m_valid_out,
    input  logic                                 m_busy,
    input  logic                                 m_erro_addr
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    arb_state_t     state, state_nx;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  grant;
    logic [N_REQ-1:0] gnt_oh;
    logic [CW-1:0]  tmo_cnt;
    logic           tmo_hit;
    logic           arb_en;
    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]  arb_idx;

    assign arb_en  = (state == IDLE);
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req     (req),
        .ptr     (ptr),
        .en      (arb_en),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        m_start  = 1'b0;
        ack      = '0;
        unique case (state)
            IDLE:  if (|req) state_nx = ISSUE;
            ISSUE: begin
                m_start = 1'b1;
                if (m_busy)       state_nx = WAIT;
                else if (tmo_hit) state_nx = DONE;
            end
            WAIT: begin
                if (!m_busy)      state_nx = DONE;
                else if (tmo_hit) state_nx = DONE;
            end
            DONE: begin
                ack      = gnt_oh;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= IW'(N_REQ - 1);
            grant    <= '0;
            gnt_oh   <= '0;
            tmo_cnt  <= '0;
            m_addr   <= '0;
            m_rw     <= 1'b0;
            m_data_w <= '0;
            rdata    <= '0;
            err_nack <= 1'b0;
            err_tmo  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (|req) begin
                        grant    <= arb_idx;
                        gnt_oh   <= arb_gnt;
                        m_addr   <= req_addr[arb_idx];
                        m_rw     <= req_rw[arb_idx];
                        m_data_w <= req_wdata[arb_idx];
                        rdata    <= '0;
                        err_nack <= 1'b0;
                        err_tmo  <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (m_busy)       tmo_cnt <= '0;
                    else if (tmo_hit) err_tmo <= 1'b1;
                    else              tmo_cnt <= tmo_cnt + CW'(1);
                end
                WAIT: begin
                    // Capture also in the busy-falling cycle; writes keep rdata at 0.
                    if (m_valid_out && m_rw) rdata <= m_data_out;
                    if (m_erro_addr)         err_nack <= 1'b1;
                    if (m_busy) begin
                        if (tmo_hit) err_tmo <= 1'b1;
                        else         tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                DONE: ptr <= grant;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
module tb_i2c_arbiter;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       req = '0;
    logic [3:0][6:0]  req_addr = '0;
    logic [3:0]       req_rw = '0;
    logic [3:0][7:0]  req_wdata = '0;
    logic [3:0]       ack;
    logic [7:0]       rdata;
    logic             err_nack, err_tmo;
    logic [6:0]       m_addr;
    logic             m_rw;
    logic [7:0]       m_data_w;
    logic             m_start;
    logic [7:0]       m_data_out = '0;
    logic             m_valid_out = 1'b0;
    logic             m_busy = 1'b0;
    logic             m_erro_addr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i2c_arbiter #(.N_REQ(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .err_nack(err_nack),
        .err_tmo(err_tmo), .m_addr(m_addr), .m_rw(m_rw), .m_data_w(m_data_w),
        .m_start(m_start), .m_data_out(m_data_out), .m_valid_out(m_valid_out),
        .m_busy(m_busy), .m_erro_addr(m_erro_addr)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference round-robin: first pending index after the last grant.
    function automatic int rr_pick(input bit [3:0] pend, input int last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_m_start"}, m_start, 0);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_m_addr"}, m_addr, 0);
        check({tag, "_m_rw"}, m_rw, 0);
        check({tag, "_m_data_w"}, m_data_w, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_err_nack"}, err_nack, 0);
        check({tag, "_err_tmo"}, err_tmo, 0);
    endtask

    // Master model for one transaction. Called at an IDLE-state negedge with
    // the request(s) already raised. Busy rises after d cycles of m_start,
    // stays high busy_len cycles; valid_at==busy_len coincides with busy fall.
    task automatic serve(input int d, input int busy_len, input int valid_at,
                         input logic [7:0] rd, input int nack_at, input bit keep,
                         input bit drop_early,
                         output int gidx, output logic [6:0] gaddr, output logic grw,
                         output logic [7:0] gwd, output logic [7:0] grd,
                         output logic gnack, output logic gtmo);
        int w;
        int sc;
        gidx = -1; gaddr = '0; grw = 0; gwd = '0; grd = '0; gnack = 0; gtmo = 0;
        @(negedge clk);
        w = 1;
        while (!m_start && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("start_latency", w, 1);
        if (!m_start) return;
        gaddr = m_addr; grw = m_rw; gwd = m_data_w;
        if (drop_early) req = '0;
        sc = 1;
        for (int i = 1; i < d; i++) begin
            @(negedge clk);
            sc += int'(m_start);
        end
        check("start_hold", sc, d);
        m_busy = 1'b1;
        for (int k = 0; k < busy_len; k++) begin
            @(negedge clk);
            if (k == 0) check("start_drop", m_start, 0);
            m_valid_out = (k == valid_at);
            m_data_out  = rd;
            m_erro_addr = (k == nack_at);
        end
        @(negedge clk);
        m_busy      = 1'b0;
        m_erro_addr = 1'b0;
        m_valid_out = (valid_at == busy_len);
        @(negedge clk);
        m_valid_out = 1'b0;
        check("ack_latency", $countones(ack), 1);
        gidx  = onehot_idx(ack);
        grd   = rdata;
        gnack = err_nack;
        gtmo  = err_tmo;
        check("addr_stable", {m_addr, m_rw, m_data_w}, {gaddr, grw, gwd});
        if (!keep && gidx >= 0) req[gidx] = 1'b0;
        @(negedge clk);
        check("ack_width", ack, 0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        m_busy = 1'b0; m_valid_out = 1'b0; m_erro_addr = 1'b0;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int         idx;
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        int         d;
        int         busy_len;
        int         valid_at;
        logic [7:0] rd;
        int         nack_at;
        bit         drop;
        int         exp_idx;
        logic [7:0] exp_rdata;
        logic       exp_nack;
    } vec_t;

    initial begin
        vec_t       vecs[6];
        int         gidx;
        logic [6:0] gaddr;
        logic       grw, gnack, gtmo;
        logic [7:0] gwd, grd;
        int         rr_exp[6];
        int         prev;
        int         sc;
        bit [3:0]   pend;
        int         last;

        vecs[0] = '{0, 7'h59, 1'b0, 8'hA5, 3, 12, -1, 8'h00, -1, 1'b0, 0, 8'h00, 1'b0};
        vecs[1] = '{2, 7'h10, 1'b1, 8'h00, 1,  6,  3, 8'h5A, -1, 1'b0, 2, 8'h5A, 1'b0};
        vecs[2] = '{1, 7'h22, 1'b0, 8'h3C, 2,  5, -1, 8'h00,  1, 1'b0, 1, 8'h00, 1'b1};
        vecs[3] = '{3, 7'h7F, 1'b1, 8'h11, 1,  4,  4, 8'hC3, -1, 1'b1, 3, 8'hC3, 1'b0};
        vecs[4] = '{2, 7'h33, 1'b1, 8'h00, 2,  5,  0, 8'h96, -1, 1'b0, 2, 8'h96, 1'b0};
        vecs[5] = '{0, 7'h00, 1'b0, 8'hFF, 1,  3,  2, 8'h77, -1, 1'b0, 0, 8'h00, 1'b0};

        // Reset values
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven single-requester transactions
        foreach (vecs[i]) begin
            req_addr[vecs[i].idx]  = vecs[i].addr;
            req_rw[vecs[i].idx]    = vecs[i].rw;
            req_wdata[vecs[i].idx] = vecs[i].wdata;
            req[vecs[i].idx]       = 1'b1;
            serve(vecs[i].d, vecs[i].busy_len, vecs[i].valid_at, vecs[i].rd,
                  vecs[i].nack_at, 1'b0, vecs[i].drop, gidx, gaddr, grw, gwd, grd, gnack, gtmo);
            check($sformatf("vec%0d_idx", i), gidx, vecs[i].exp_idx);
            check($sformatf("vec%0d_addr", i), gaddr, vecs[i].addr);
            check($sformatf("vec%0d_rw", i), grw, vecs[i].rw);
            check($sformatf("vec%0d_wdata", i), gwd, vecs[i].wdata);
            check($sformatf("vec%0d_rdata", i), grd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_nack", i), gnack, vecs[i].exp_nack);
            check($sformatf("vec%0d_tmo", i), gtmo, 0);
        end

        // Reset mid-WAIT: last grant was 0, so without a pointer reset 1 would win next.
        req_addr[1] = 7'h41; req_rw[1] = 1'b0; req_wdata[1] = 8'h12;
        req[1] = 1'b1;
        @(negedge clk);
        check("rst_pre_start", m_start, 1);
        m_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req_addr[0] = 7'h05; req_rw[0] = 1'b0; req_wdata[0] = 8'h34;
        req[0] = 1'b1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        m_busy = 1'b0;
        sc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sc += $countones(ack);
        end
        check("rst_no_ack", sc, 0);
        rst_n = 1'b1;
        serve(1, 3, -1, 8'h00, -1, 1'b0, 1'b0, gidx, gaddr, grw, gwd, grd, gnack, gtmo);
        check("rst_regrant_idx", gidx, 0);
        check("rst_regrant_addr", gaddr, 7'h05);
        serve(1, 3, -1, 8'h00, -1, 1'b0, 1'b0, gidx, gaddr, grw, gwd, grd, gnack, gtmo);
        check("rst_second_idx", gidx, 1);

        // Round-robin with requesters 0, 1, 3 held continuously from reset
        reset_dut();
        rr_exp = '{0, 1, 3, 0, 1, 3};
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 7'(8'h20 + i); req_rw[i] = 1'b0; req_wdata[i] = 8'(i);
        end
        req = 4'b1011;
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            serve(1, 2, -1, 8'h00, -1, 1'b1, 1'b0, gidx, gaddr, grw, gwd, grd, gnack, gtmo);
            check($sformatf("rr%0d_idx", i), gidx, rr_exp[i]);
            check($sformatf("rr%0d_no_repeat", i), (gidx != prev), 1);
            prev = gidx;
        end
        req = '0;

        // ISSUE timeout: master never raises busy
        req_addr[2] = 7'h6E; req_rw[2] = 1'b1;
        req[2] = 1'b1;
        sc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ack != 0) break;
            sc += int'(m_start);
        end
        check("tmo_start_cycles", sc, 16);
        check("tmo_ack", ack, 4'b0100);
        check("tmo_err_tmo", err_tmo, 1);
        check("tmo_err_nack", err_nack, 0);
        check("tmo_rdata", rdata, 0);
        req = '0;
        @(negedge clk);
        check("tmo_ack_width", ack, 0);

        // Randomized traffic against the reference model
        reset_dut();
        pend = '0;
        last = 3;
        for (int t = 0; t < 40; t++) begin
            int   d, l, va, na, e;
            logic [7:0] rd;
            for (int r = 0; r < 4; r++) begin
                if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
                    req_addr[r]  = 7'($urandom);
                    req_rw[r]    = 1'($urandom);
                    req_wdata[r] = 8'($urandom);
                    pend[r] = 1'b1;
                    req[r]  = 1'b1;
                end
            end
            if (pend == 0) begin
                req_addr[t % 4] = 7'($urandom); req_rw[t % 4] = 1'($urandom);
                req_wdata[t % 4] = 8'($urandom);
                pend[t % 4] = 1'b1; req[t % 4] = 1'b1;
            end
            e  = rr_pick(pend, last);
            d  = $urandom_range(1, 3);
            l  = $urandom_range(1, 6);
            va = $urandom_range(0, l + 1);
            if (va > l) va = -1;
            na = ($urandom_range(0, 1) == 1) ? $urandom_range(0, l - 1) : -1;
            rd = 8'($urandom);
            serve(d, l, va, rd, na, 1'b0, 1'b0, gidx, gaddr, grw, gwd, grd, gnack, gtmo);
            check($sformatf("rnd%0d_idx", t), gidx, e);
            check($sformatf("rnd%0d_cmd", t), {gaddr, grw, gwd}, {req_addr[e], req_rw[e], req_wdata[e]});
            check($sformatf("rnd%0d_rdata", t), grd, (req_rw[e] && va >= 0) ? rd : 8'h00);
            check($sformatf("rnd%0d_nack", t), gnack, (na >= 0));
            check($sformatf("rnd%0d_tmo", t), gtmo, 0);
            pend[e] = 1'b0;
            req[e]  = 1'b0;
            last = e;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
